usb_spectrum_tx: RTL and testbench

USB_SPECTRUM_TX -- requirements
Module: usb_spectrum_tx

---
 rtl/usb_tx_pkg.sv | 40 ++++
 rtl/usb_spectrum_tx_if.sv | 26 ++
 rtl/usb_spectrum_tx.sv | 104 ++++++++++
 tb/tb_usb_spectrum_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB spectrum frame transmitter.
// Frame: header, length, hi/lo word pairs per channel, then a 16-bit additive checksum.
package usb_tx_pkg;

  localparam int          ADDR_W       = 10;
  localparam logic [15:0] HDR_WORD_DEF = 16'hA55A;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_LEN,
    ST_ADDR,
    ST_FETCH,
    ST_HI,
    ST_LO,
    ST_CSUM,
    ST_FIN
  } state_e;

  typedef enum logic [2:0] {
    WORD_NONE,
    WORD_HDR,
    WORD_LEN,
    WORD_HI,
    WORD_LO,
    WORD_CSUM
  } word_e;

  function automatic word_e word_of(state_e s);
    case (s)
      ST_HDR:  return WORD_HDR;
      ST_LEN:  return WORD_LEN;
      ST_HI:   return WORD_HI;
      ST_LO:   return WORD_LO;
      ST_CSUM: return WORD_CSUM;
      default: return WORD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/usb_spectrum_tx_if.sv
// Control, spectrum memory read port and USB write port of the transmitter.
// master = transmitter side, slave = surrounding system / bench.
interface usb_spectrum_tx_if;
  import usb_tx_pkg::*;

  logic              send_req;
  logic              abort;
  logic [ADDR_W-1:0] channel_address;
  logic [31:0]       channel_count;
  logic [15:0]       usb_write_data;
  logic              usb_write_en;
  logic              usb_write_wait;
  logic              busy;
  logic              done;

  modport master (
    input  send_req, abort, channel_count, usb_write_wait,
    output channel_address, usb_write_data, usb_write_en, busy, done
  );

  modport slave (
    output send_req, abort, channel_count, usb_write_wait,
    input  channel_address, usb_write_data, usb_write_en, busy, done
  );

endinterface

// File: rtl/usb_spectrum_tx.sv
// Streams one spectrum frame from memory to the USB write path with backpressure.
//
// state | meaning
// IDLE  | waiting for send_req
// HDR   | offering header word
// LEN   | offering channel-count word
// ADDR  | channel_address presented to memory
// FETCH | memory data latched into holding register
// HI    | offering channel_count[31:16]
// LO    | offering channel_count[15:0]
// CSUM  | offering checksum word
// FIN   | done pulse, back to IDLE
module usb_spectrum_tx
  import usb_tx_pkg::*;
#(
  parameter int          NUM_CH   = 1024,
  parameter logic [15:0] HDR_WORD = HDR_WORD_DEF
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  usb_spectrum_tx_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CH - 1);
  localparam logic [15:0]       LEN_WORD  = 16'(NUM_CH);

  state_e            state, state_nxt;
  word_e             word;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       hold;
  logic [15:0]       csum;
  logic [15:0]       data;
  logic              xfer;
  logic              start;
  logic              kill;

  assign word  = word_of(state);
  assign xfer  = (word != WORD_NONE) && !bus.usb_write_wait;
  assign start = (state == ST_IDLE) && bus.send_req && !bus.abort;
  assign kill  = (state != ST_IDLE) && bus.abort;

  always_comb begin
    data = 16'h0000;
    case (word)
      WORD_HDR:  data = HDR_WORD;
      WORD_LEN:  data = LEN_WORD;
      WORD_HI:   data = hold[31:16];
      WORD_LO:   data = hold[15:0];
      WORD_CSUM: data = csum;
      default:   data = 16'h0000;
    endcase
  end

  assign bus.usb_write_data  = data;
  assign bus.usb_write_en    = (word != WORD_NONE);
  assign bus.channel_address = addr;
  assign bus.busy            = (state != ST_IDLE) && (state != ST_FIN);
  assign bus.done            = (state == ST_FIN);

  always_comb begin
    state_nxt = state;
    if (kill) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state_nxt = ST_HDR;
        ST_HDR:   if (xfer) state_nxt = ST_LEN;
        ST_LEN:   if (xfer) state_nxt = ST_ADDR;
        ST_ADDR:  state_nxt = ST_FETCH;
        ST_FETCH: state_nxt = ST_HI;
        ST_HI:    if (xfer) state_nxt = ST_LO;
        ST_LO:    if (xfer) state_nxt = (addr < LAST_ADDR) ? ST_ADDR : ST_CSUM;
        ST_CSUM:  if (xfer) state_nxt = ST_FIN;
        ST_FIN:   state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state <= ST_IDLE;
      addr  <= '0;
      hold  <= '0;
      csum  <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        addr <= '0;
        csum <= '0;
      end else if (kill) begin
        csum <= '0;
      end else begin
        // memory data is only sampled here, so a stalled word is never re-read
        if (state == ST_FETCH) hold <= bus.channel_count;
        if (xfer && (word == WORD_LEN || word == WORD_HI || word == WORD_LO))
          csum <= csum + data;
        if (state == ST_LO && xfer && addr < LAST_ADDR)
          addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_usb_spectrum_tx.sv
// Scoreboard bench for usb_spectrum_tx with a 4-channel registered memory model.
module tb_usb_spectrum_tx;
  import usb_tx_pkg::*;

  localparam int NCH = 4;

  logic CLOCK_50 = 1'b0;
  logic rst      = 1'b1;

  usb_spectrum_tx_if bus ();

  usb_spectrum_tx #(.NUM_CH(NCH), .HDR_WORD(16'hA55A)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .bus      (bus.master)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [31:0] mem [NCH];
  initial begin
    mem[0] = 32'h12345678;
    mem[1] = 32'h00000000;
    mem[2] = 32'hFFFFFFFF;
    mem[3] = 32'h00000001;
  end

  always @(posedge CLOCK_50) bus.channel_count <= mem[bus.channel_address[1:0]];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  logic [15:0] exp_q[$];

  task automatic push_frame();
    logic [15:0] s;
    exp_q.push_back(16'hA55A);
    exp_q.push_back(16'(NCH));
    s = 16'(NCH);
    for (int i = 0; i < NCH; i++) begin
      exp_q.push_back(mem[i][31:16]);
      exp_q.push_back(mem[i][15:0]);
      s = s + mem[i][31:16] + mem[i][15:0];
    end
    exp_q.push_back(s);
  endtask

  int          words_seen   = 0;
  int          done_cnt     = 0;
  int          en_cnt       = 0;
  int          stall_cycles = 0;
  logic        prev_stall   = 1'b0;
  logic [15:0] prev_data    = '0;

  // Transfers are judged at the falling edge; inputs only change just after a rising edge.
  always @(negedge CLOCK_50) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.done) done_cnt++;
      if (bus.usb_write_en) en_cnt++;
      if (prev_stall) begin
        chk("stall_en_hold", 32'(bus.usb_write_en), 32'd1);
        chk("stall_data_hold", 32'(bus.usb_write_data), 32'(prev_data));
      end
      prev_stall = 1'b0;
      if (bus.usb_write_en && !bus.abort) begin
        if (bus.usb_write_wait) begin
          prev_stall = 1'b1;
          prev_data  = bus.usb_write_data;
          stall_cycles++;
        end else begin
          words_seen++;
          chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0)
            chk("frame_word", 32'(bus.usb_write_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  logic stall_en   = 1'b0;
  int   stall_left = 0;
  int   stall_base = 0;
  logic stalled_a  = 1'b0;
  logic stalled_b  = 1'b0;

  always begin
    @(posedge CLOCK_50);
    #1;
    if (!stall_en) begin
      bus.usb_write_wait = 1'b0;
    end else if (stall_left > 0) begin
      bus.usb_write_wait = 1'b1;
      stall_left--;
    end else if (bus.usb_write_en && bus.usb_write_data == 16'h1234 && !stalled_a) begin
      stalled_a = 1'b1;
      bus.usb_write_wait = 1'b1;
      stall_left = 4;
    end else if (bus.usb_write_en && (words_seen - stall_base) == 10 && !stalled_b) begin
      stalled_b = 1'b1;
      bus.usb_write_wait = 1'b1;
      stall_left = 4;
    end else begin
      bus.usb_write_wait = 1'b0;
    end
  end

  task automatic cycle();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send();
    bus.send_req = 1'b1;
    cycle();
    bus.send_req = 1'b0;
  endtask

  task automatic wait_done(input int base_done);
    for (int i = 0; i < 400; i++) begin
      if (done_cnt != base_done) break;
      cycle();
    end
    chk("done_seen", 32'(done_cnt - base_done), 32'd1);
  endtask

  task automatic wait_words(input int base_words, input int n);
    for (int i = 0; i < 400; i++) begin
      if (words_seen - base_words == n) break;
      cycle();
    end
    chk("sync_words", 32'(words_seen - base_words), 32'(n));
  endtask

  task automatic full_frame(input string tag);
    int wb;
    int db;
    wb = words_seen;
    db = done_cnt;
    push_frame();
    send();
    wait_done(db);
    repeat (3) cycle();
    chk({tag, "_words"}, 32'(words_seen - wb), 32'd11);
    chk({tag, "_done_once"}, 32'(done_cnt - db), 32'd1);
    chk({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
    chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int wb;
    int db;
    int sb;
    int eb;
    bus.send_req = 1'b0;
    bus.abort    = 1'b0;
    rst          = 1'b1;
    repeat (3) cycle();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_en", 32'(bus.usb_write_en), 32'd0);
    chk("rst_data", 32'(bus.usb_write_data), 32'd0);
    chk("rst_addr", 32'(bus.channel_address), 32'd0);
    rst = 1'b0;
    repeat (2) cycle();

    // frame with no backpressure, busy must rise the cycle after send_req
    db = done_cnt;
    wb = words_seen;
    push_frame();
    chk("busy_pre", 32'(bus.busy), 32'd0);
    send();
    chk("busy_rise", 32'(bus.busy), 32'd1);
    wait_done(db);
    repeat (3) cycle();
    chk("plain_words", 32'(words_seen - wb), 32'd11);
    chk("plain_done_once", 32'(done_cnt - db), 32'd1);
    chk("plain_busy_low", 32'(bus.busy), 32'd0);
    chk("plain_q_empty", 32'(exp_q.size()), 32'd0);

    // stalls on the 1234 word and on the checksum word
    sb = stall_cycles;
    stall_base = words_seen;
    stalled_a = 1'b0;
    stalled_b = 1'b0;
    stall_en = 1'b1;
    full_frame("stall");
    stall_en = 1'b0;
    chk("stall_cycles", 32'(stall_cycles - sb), 32'd10);

    // abort while the FFFF low word is offered
    db = done_cnt;
    wb = words_seen;
    push_frame();
    send();
    wait_words(wb, 7);
    bus.abort = 1'b1;
    cycle();
    bus.abort = 1'b0;
    chk("abort_en", 32'(bus.usb_write_en), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_words", 32'(words_seen - wb), 32'd7);
    exp_q.delete();
    repeat (5) cycle();
    chk("abort_no_done", 32'(done_cnt - db), 32'd0);
    full_frame("post_abort");

    // second send_req mid-frame is ignored
    db = done_cnt;
    wb = words_seen;
    push_frame();
    send();
    repeat (6) cycle();
    send();
    wait_done(db);
    repeat (20) cycle();
    chk("dup_req_words", 32'(words_seen - wb), 32'd11);
    chk("dup_req_done", 32'(done_cnt - db), 32'd1);
    chk("dup_req_q_empty", 32'(exp_q.size()), 32'd0);

    // send_req with abort in IDLE starts nothing
    eb = en_cnt;
    bus.send_req = 1'b1;
    bus.abort    = 1'b1;
    cycle();
    bus.send_req = 1'b0;
    bus.abort    = 1'b0;
    repeat (5) cycle();
    chk("abort_idle_busy", 32'(bus.busy), 32'd0);
    chk("abort_idle_en", 32'(en_cnt - eb), 32'd0);

    // reset during LO of channel 1
    db = done_cnt;
    wb = words_seen;
    push_frame();
    send();
    wait_words(wb, 5);
    rst = 1'b1;
    cycle();
    chk("midrst_en", 32'(bus.usb_write_en), 32'd0);
    chk("midrst_data", 32'(bus.usb_write_data), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_addr", 32'(bus.channel_address), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    eb = en_cnt;
    repeat (20) cycle();
    chk("midrst_quiet", 32'(en_cnt - eb), 32'd0);
    chk("midrst_no_done", 32'(done_cnt - db), 32'd0);
    full_frame("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected finish");
    $fatal(1);
  end

endmodule
